// File: rtl/id_operand_fetch_pkg.sv
// Shared widths, instruction field positions and reset values for the
// decode-stage operand fetch.
package id_operand_fetch_pkg;

    localparam int WORD_DATA_W = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int REG_ADDR_W  = 5;
    localparam int INSN_W      = 32;

    typedef logic [WORD_DATA_W-1:0] word_data_bus_t;
    typedef logic [REG_ADDR_W-1:0]  reg_addr_bus_t;

    // Instruction field bit positions
    localparam int RA_LOC_HI  = 25;
    localparam int RA_LOC_LO  = 21;
    localparam int RB_LOC_HI  = 20;
    localparam int RB_LOC_LO  = 16;
    localparam int IMM_LOC_HI = 15;
    localparam int IMM_LOC_LO = 0;

    // Active-low write-enable encoding used by the EX/MEM stages
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam logic ID_EN_RESET = 1'b0;

endpackage

// File: rtl/id_operand_fetch_fwd_mux.sv
// Single-operand forward selector: EX result, then MEM result, then
// register-file read data. Address 0 forwards like any other register.
module id_operand_fetch_fwd_mux
    import id_operand_fetch_pkg::*;
#(
    parameter int DATA_W = WORD_DATA_W,
    parameter int REG_AW = REG_ADDR_W
) (
    input  logic              ex_en,
    input  logic              ex_gpr_we_,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_dst_addr,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              mem_en,
    input  logic              mem_gpr_we_,
    input  logic [REG_AW-1:0] mem_dst_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] operand
);

    logic ex_hit;
    logic mem_hit;

    // A load in EX has no data yet; that case is covered by the hazard stall.
    assign ex_hit  = ex_en && (ex_gpr_we_ == ENABLE_) && !ex_is_load
                     && (ex_dst_addr == rd_addr);
    assign mem_hit = mem_en && (mem_gpr_we_ == ENABLE_)
                     && (mem_dst_addr == rd_addr);

    always_comb begin
        operand = rd_data;
        if (ex_hit) begin
            operand = ex_fwd_data;
        end else if (mem_hit) begin
            operand = mem_fwd_data;
        end
    end

endmodule

// File: rtl/id_operand_fetch.sv
// Decode-stage operand fetch: drives register-file read addresses, resolves
// forwarded operands, detects load-use hazards and loads the ID/EX register.
module id_operand_fetch
    import id_operand_fetch_pkg::*;
#(
    parameter int DATA_W = WORD_DATA_W,
    parameter int ADDR_W = WORD_ADDR_W,
    parameter int REG_AW = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INSN_W-1:0] if_insn,
    input  logic              if_en,
    input  logic              stall,
    input  logic              flush,
    output logic [REG_AW-1:0] gpr_rd_addr_0,
    output logic [REG_AW-1:0] gpr_rd_addr_1,
    input  logic [DATA_W-1:0] gpr_rd_data_0,
    input  logic [DATA_W-1:0] gpr_rd_data_1,
    input  logic              ex_en,
    input  logic              ex_gpr_we_,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_dst_addr,
    input  logic [DATA_W-1:0] ex_fwd_data,
    input  logic              mem_en,
    input  logic              mem_gpr_we_,
    input  logic [REG_AW-1:0] mem_dst_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    output logic              load_hazard,
    output logic              id_en,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INSN_W-1:0] id_insn,
    output logic [DATA_W-1:0] id_ra_data,
    output logic [DATA_W-1:0] id_rb_data,
    output logic [DATA_W-1:0] id_imm_s
);

    logic [DATA_W-1:0] ra_resolved;
    logic [DATA_W-1:0] rb_resolved;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_s;

    assign gpr_rd_addr_0 = if_insn[RA_LOC_HI:RA_LOC_LO];
    assign gpr_rd_addr_1 = if_insn[RB_LOC_HI:RB_LOC_LO];
    assign imm           = if_insn[IMM_LOC_HI:IMM_LOC_LO];
    assign imm_s         = {{(DATA_W-16){imm[15]}}, imm};

    // Both fields are compared regardless of whether the opcode reads rb.
    assign load_hazard = if_en && ex_en && (ex_gpr_we_ == ENABLE_) && ex_is_load
                         && ((ex_dst_addr == gpr_rd_addr_0) || (ex_dst_addr == gpr_rd_addr_1));

    id_operand_fetch_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_ra (
        .ex_en        (ex_en),
        .ex_gpr_we_   (ex_gpr_we_),
        .ex_is_load   (ex_is_load),
        .ex_dst_addr  (ex_dst_addr),
        .ex_fwd_data  (ex_fwd_data),
        .mem_en       (mem_en),
        .mem_gpr_we_  (mem_gpr_we_),
        .mem_dst_addr (mem_dst_addr),
        .mem_fwd_data (mem_fwd_data),
        .rd_addr      (gpr_rd_addr_0),
        .rd_data      (gpr_rd_data_0),
        .operand      (ra_resolved)
    );

    id_operand_fetch_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rb (
        .ex_en        (ex_en),
        .ex_gpr_we_   (ex_gpr_we_),
        .ex_is_load   (ex_is_load),
        .ex_dst_addr  (ex_dst_addr),
        .ex_fwd_data  (ex_fwd_data),
        .mem_en       (mem_en),
        .mem_gpr_we_  (mem_gpr_we_),
        .mem_dst_addr (mem_dst_addr),
        .mem_fwd_data (mem_fwd_data),
        .rd_addr      (gpr_rd_addr_1),
        .rd_data      (gpr_rd_data_1),
        .operand      (rb_resolved)
    );

    // id_en is the valid flag of the ID/EX slot; there is no ready path,
    // downstream back-pressure arrives only as stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_en      <= ID_EN_RESET;
            id_pc      <= '0;
            id_insn    <= '0;
            id_ra_data <= '0;
            id_rb_data <= '0;
            id_imm_s   <= '0;
        end else if (flush) begin
            id_en   <= 1'b0;
            id_insn <= '0;
        end else if (stall) begin
            id_en <= id_en;
        end else if (load_hazard) begin
            id_en   <= 1'b0;
            id_insn <= '0;
        end else begin
            id_en      <= if_en;
            id_pc      <= if_pc;
            id_insn    <= if_insn;
            id_ra_data <= ra_resolved;
            id_rb_data <= rb_resolved;
            id_imm_s   <= imm_s;
        end
    end

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch: forwarding priority, load-use bubbles,
// stall/flush interplay and reset behaviour.
module tb_id_operand_fetch;

    logic        clk;
    logic        reset;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;
    logic        stall;
    logic        flush;
    logic [4:0]  gpr_rd_addr_0;
    logic [4:0]  gpr_rd_addr_1;
    logic [31:0] gpr_rd_data_0;
    logic [31:0] gpr_rd_data_1;
    logic        ex_en;
    logic        ex_gpr_we_;
    logic        ex_is_load;
    logic [4:0]  ex_dst_addr;
    logic [31:0] ex_fwd_data;
    logic        mem_en;
    logic        mem_gpr_we_;
    logic [4:0]  mem_dst_addr;
    logic [31:0] mem_fwd_data;
    logic        load_hazard;
    logic        id_en;
    logic [29:0] id_pc;
    logic [31:0] id_insn;
    logic [31:0] id_ra_data;
    logic [31:0] id_rb_data;
    logic [31:0] id_imm_s;

    int n_checks = 0;
    int n_pass   = 0;

    id_operand_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .if_pc         (if_pc),
        .if_insn       (if_insn),
        .if_en         (if_en),
        .stall         (stall),
        .flush         (flush),
        .gpr_rd_addr_0 (gpr_rd_addr_0),
        .gpr_rd_addr_1 (gpr_rd_addr_1),
        .gpr_rd_data_0 (gpr_rd_data_0),
        .gpr_rd_data_1 (gpr_rd_data_1),
        .ex_en         (ex_en),
        .ex_gpr_we_    (ex_gpr_we_),
        .ex_is_load    (ex_is_load),
        .ex_dst_addr   (ex_dst_addr),
        .ex_fwd_data   (ex_fwd_data),
        .mem_en        (mem_en),
        .mem_gpr_we_   (mem_gpr_we_),
        .mem_dst_addr  (mem_dst_addr),
        .mem_fwd_data  (mem_fwd_data),
        .load_hazard   (load_hazard),
        .id_en         (id_en),
        .id_pc         (id_pc),
        .id_insn       (id_insn),
        .id_ra_data    (id_ra_data),
        .id_rb_data    (id_rb_data),
        .id_imm_s      (id_imm_s)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic en, input logic we_, input logic ld,
                          input logic [4:0] dst, input logic [31:0] data);
        ex_en       = en;
        ex_gpr_we_  = we_;
        ex_is_load  = ld;
        ex_dst_addr = dst;
        ex_fwd_data = data;
    endtask

    task automatic set_mem(input logic en, input logic we_,
                           input logic [4:0] dst, input logic [31:0] data);
        mem_en       = en;
        mem_gpr_we_  = we_;
        mem_dst_addr = dst;
        mem_fwd_data = data;
    endtask

    initial begin
        reset = 1'b1;
        if_en = 1'b1;
        if_pc = 30'h3ABC;
        if_insn = 32'h0421_FFFF;
        stall = 1'b0;
        flush = 1'b0;
        gpr_rd_data_0 = 32'h1234;
        gpr_rd_data_1 = 32'h5678;
        set_ex(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        set_mem(1'b0, 1'b1, 5'd0, 32'h0);

        // Reset
        tick();
        check("rst_en",   {31'b0, id_en}, 32'h0);
        check("rst_pc",   {2'b0, id_pc}, 32'h0);
        check("rst_insn", id_insn, 32'h0);
        check("rst_ra",   id_ra_data, 32'h0);
        check("rst_rb",   id_rb_data, 32'h0);
        check("rst_imm",  id_imm_s, 32'h0);

        // Plain fetch: ra=1 rb=2 imm=0x8000
        reset = 1'b0;
        if_pc = 30'h123;
        if_insn = 32'h0022_8000;
        gpr_rd_data_0 = 32'h11;
        gpr_rd_data_1 = 32'h22;
        #1;
        check("rd_addr_0", {27'b0, gpr_rd_addr_0}, 32'd1);
        check("rd_addr_1", {27'b0, gpr_rd_addr_1}, 32'd2);
        tick();
        check("plain_en",   {31'b0, id_en}, 32'h1);
        check("plain_pc",   {2'b0, id_pc}, 32'h123);
        check("plain_insn", id_insn, 32'h0022_8000);
        check("plain_ra",   id_ra_data, 32'h11);
        check("plain_rb",   id_rb_data, 32'h22);
        check("plain_imm",  id_imm_s, 32'hFFFF_8000);

        // Forward priority on ra
        set_ex(1'b1, 1'b0, 1'b0, 5'd1, 32'hAAAA);
        set_mem(1'b1, 1'b0, 5'd1, 32'hBBBB);
        tick();
        check("fwd_ex_ra", id_ra_data, 32'hAAAA);
        check("fwd_ex_rb", id_rb_data, 32'h22);
        set_ex(1'b1, 1'b1, 1'b0, 5'd1, 32'hAAAA);
        tick();
        check("fwd_ex_we_off", id_ra_data, 32'hBBBB);
        set_ex(1'b0, 1'b0, 1'b0, 5'd1, 32'hAAAA);
        tick();
        check("fwd_mem_ra", id_ra_data, 32'hBBBB);
        set_mem(1'b1, 1'b1, 5'd1, 32'hBBBB);
        tick();
        check("fwd_gpr_ra", id_ra_data, 32'h11);
        set_mem(1'b1, 1'b0, 5'd2, 32'hCCCC);
        tick();
        check("fwd_mem_rb", id_rb_data, 32'hCCCC);
        set_mem(1'b0, 1'b1, 5'd0, 32'h0);

        // Load-use: EX load to r3, insn ra=4 rb=3 imm=1
        set_ex(1'b1, 1'b0, 1'b1, 5'd3, 32'hDEAD);
        if_pc = 30'h200;
        if_insn = 32'h0083_0001;
        #1;
        check("lu_hazard", {31'b0, load_hazard}, 32'h1);
        if_en = 1'b0;
        #1;
        check("lu_hazard_if_off", {31'b0, load_hazard}, 32'h0);
        if_en = 1'b1;
        tick();
        check("lu_bubble_en",   {31'b0, id_en}, 32'h0);
        check("lu_bubble_insn", id_insn, 32'h0);
        check("lu_bubble_pc",   {2'b0, id_pc}, 32'h123);
        set_ex(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        set_mem(1'b1, 1'b0, 5'd3, 32'h55);
        #1;
        check("lu_clear", {31'b0, load_hazard}, 32'h0);
        tick();
        check("lu_en",  {31'b0, id_en}, 32'h1);
        check("lu_rb",  id_rb_data, 32'h55);
        check("lu_imm", id_imm_s, 32'h1);
        set_mem(1'b0, 1'b1, 5'd0, 32'h0);

        // Stall for two cycles holds everything
        stall = 1'b1;
        if_pc = 30'h300;
        if_insn = 32'h0022_0004;
        tick();
        tick();
        check("stall_en",   {31'b0, id_en}, 32'h1);
        check("stall_pc",   {2'b0, id_pc}, 32'h200);
        check("stall_insn", id_insn, 32'h0083_0001);
        check("stall_rb",   id_rb_data, 32'h55);

        // Flush beats stall
        flush = 1'b1;
        tick();
        check("flush_en",   {31'b0, id_en}, 32'h0);
        check("flush_insn", id_insn, 32'h0);
        flush = 1'b0;
        stall = 1'b0;
        tick();
        check("refill_en",   {31'b0, id_en}, 32'h1);
        check("refill_insn", id_insn, 32'h0022_0004);

        // Stall together with a hazard: no bubble until the stall drops
        set_ex(1'b1, 1'b0, 1'b1, 5'd1, 32'h0);
        stall = 1'b1;
        if_insn = 32'h0022_0008;
        #1;
        check("sh_hazard", {31'b0, load_hazard}, 32'h1);
        tick();
        check("sh_en",   {31'b0, id_en}, 32'h1);
        check("sh_insn", id_insn, 32'h0022_0004);
        stall = 1'b0;
        tick();
        check("sh_bubble_en", {31'b0, id_en}, 32'h0);

        // Address 0 forwards like any register
        set_ex(1'b1, 1'b0, 1'b0, 5'd0, 32'h7);
        if_insn = 32'h0005_0000;
        gpr_rd_data_0 = 32'h99;
        tick();
        check("r0_fwd", id_ra_data, 32'h7);

        // Reset while a hazard is present
        set_ex(1'b1, 1'b0, 1'b1, 5'd5, 32'h0);
        reset = 1'b1;
        #1;
        check("rst_hz_comb", {31'b0, load_hazard}, 32'h1);
        tick();
        check("rst_hz_en", {31'b0, id_en}, 32'h0);
        check("rst_hz_pc", {2'b0, id_pc}, 32'h0);
        reset = 1'b0;

        // if_en=0: capture with id_en=0 and no hazard despite a matching load
        if_en = 1'b0;
        if_pc = 30'h444;
        #1;
        check("ifoff_hazard", {31'b0, load_hazard}, 32'h0);
        tick();
        check("ifoff_en", {31'b0, id_en}, 32'h0);
        check("ifoff_pc", {2'b0, id_pc}, 32'h444);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_operand_fetch.md
Name: id_operand_fetch

Overview:
- Operand-fetch half of the decode stage; sits directly upstream of the general-purpose register file.
- Takes the IF-stage instruction and drives the two register-file read addresses from it.
- Selects each operand from three sources: EX-stage forward, MEM-stage forward, or register-file read data.
- Detects load-use hazards and registers the result into the ID/EX pipeline register, with stall, flush and bubble insertion.

Parameters:
- DATA_W, 32, word data width (matches the word data bus).
- ADDR_W, 30, word-address PC width.
- REG_AW, 5, register address width (REG_NUM = 2**REG_AW).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_pc  in  ADDR_W  PC of the IF instruction
- if_insn  in  32  instruction; ra = [25:21], rb = [20:16], imm = [15:0]
- if_en  in  1  IF instruction valid
- stall  in  1  hold ID/EX register (from pipeline control)
- flush  in  1  kill ID/EX contents
- gpr_rd_addr_0  out  REG_AW  read address 0 = if_insn[25:21], combinational
- gpr_rd_addr_1  out  REG_AW  read address 1 = if_insn[20:16], combinational
- gpr_rd_data_0  in  DATA_W  read data 0 (already write-bypassed by the register file)
- gpr_rd_data_1  in  DATA_W  read data 1
- ex_en, ex_gpr_we_, ex_is_load  in  1 each  EX valid, EX write enable (active-low), EX instruction is a load
- ex_dst_addr  in  REG_AW  EX destination register
- ex_fwd_data  in  DATA_W  EX result
- mem_en, mem_gpr_we_  in  1 each  MEM valid, MEM write enable (active-low)
- mem_dst_addr  in  REG_AW  MEM destination register
- mem_fwd_data  in  DATA_W  MEM result
- load_hazard  out  1  combinational; pipeline control must hold IF/PC while high
- id_en  out  1  ID/EX valid
- id_pc  out  ADDR_W  registered PC
- id_insn  out  32  registered instruction
- id_ra_data, id_rb_data  out  DATA_W each  resolved operands
- id_imm_s  out  DATA_W  sign-extended imm

Behaviour:
- Operand select for ra (rb identical, using addr_1/data_1). Priority, highest first:
  - ex_en && !ex_gpr_we_ && !ex_is_load && ex_dst_addr==ra -> ex_fwd_data
  - mem_en && !mem_gpr_we_ && mem_dst_addr==ra -> mem_fwd_data
  - otherwise gpr_rd_data_0
- No register is hardwired to zero; address 0 forwards like any other register.
- load_hazard = if_en && ex_en && !ex_gpr_we_ && ex_is_load && (ex_dst_addr==ra || ex_dst_addr==rb).
  - Both fields are always compared (conservative).
- ID/EX register update on posedge clk, priority highest first:
  - reset: id_en=0, id_pc=0, id_insn=0, id_ra_data=0, id_rb_data=0, id_imm_s=0.
  - flush: id_en=0, id_insn=0; data fields may hold.
  - stall: all fields hold.
  - load_hazard: bubble; id_en=0, id_insn=0, other fields hold.
  - else: capture; id_en=if_en, id_pc=if_pc, id_insn=if_insn, resolved operands, id_imm_s={{16{imm[15]}},imm}.
- Latency: 1 cycle from IF inputs to id_* outputs.
- Hazard self-clears: the bubble reaches EX next cycle, and the load is then in MEM and forwarded via the MEM path.
- stall and load_hazard in the same cycle: stall wins, no bubble; the hazard is re-evaluated the next cycle.
- flush and stall in the same cycle: flush wins.
- Reset mid-hazard: id_en=0 next cycle; load_hazard itself is purely combinational from inputs.
- if_en=0 with no stall/flush: registers capture, id_en=0, and load_hazard is forced 0.

Decomposition:
- Shared package/header:
  - REG_AW / WordDataBus / RegAddrBus widths
  - instruction field bit positions (RA_LOC, RB_LOC, IMM_LOC)
  - ENABLE_/DISABLE_ active-low constants
  - reset-value constants
- One natural sub-module: fwd_mux, a single-operand 3-way priority forward selector, instantiated twice.

Test Plan:
- Reset: assert reset with if_en=1, insn=0x0421_FFFF -> next edge id_en=0, all id_* = 0.
- Plain fetch: gpr_rd_data_0=0x11, gpr_rd_data_1=0x22, no forwards, insn ra=1, rb=2, imm=0x8000 -> id_ra_data=0x11, id_rb_data=0x22, id_imm_s=0xFFFF_8000, id_en=1.
- Forward priority: EX and MEM both write r1 (0xAAAA vs 0xBBBB), insn ra=1 -> id_ra_data=0xAAAA. Drop EX -> 0xBBBB. Set MEM we_=1 -> GPR value.
- Load-use: EX load to r3, insn rb=3 -> load_hazard=1 and id_en=0 next cycle. Next cycle the load is in MEM with data 0x55 -> load_hazard=0, id_rb_data=0x55.
- Stall/flush interplay:
  - stall=1 for 2 cycles -> outputs unchanged.
  - flush=1 with stall=1 -> id_en=0.
  - stall with load_hazard -> no bubble; id_en keeps its previous value.
- Address-0 forward: EX writes r0=0x7, insn ra=0 -> id_ra_data=0x7.
